servo_pwm_capture: RTL

Receive-side counterpart of the servo PWM generator. Measures the high time of an incoming 50 Hz servo-style pulse train and decodes it back to the 3-bit position code (1..5) the generator encodes. It also reports the raw width, flags malformed pulses, and flags loss of signal. It sits between an external or looped-back PWM pin and the control logic: for loopback self-test of the servo path and for reading RC-receiver channels.

---
 rtl/servo_pwm_capture.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures pulse high time, decodes position code 1..5,
// flags malformed or stuck-high pulses and loss of signal.
module servo_pwm_capture #(
    parameter int FRAME       = 2000000,
    parameter int TOL         = 10000,
    parameter int MAX_HIGH    = 300000,
    parameter int LOST_FRAMES = 3,
    parameter int NOM_MIN     = 70000,
    parameter int NOM_STEP    = 40000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [2:0]  value,
    output logic [20:0] width,
    output logic        valid,
    output logic        err,
    output logic        lost
);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE,
        STUCK
    } state_t;

    localparam logic [22:0] LOST_CNT = 23'(LOST_FRAMES * FRAME);
    localparam logic [20:0] CNT_MAX  = 21'(MAX_HIGH);
    localparam logic [21:0] TOL_W    = 22'(TOL);

    state_t      state;
    state_t      state_n;
    logic        s1;
    logic        s2;
    logic        s3;
    logic        rise;
    logic        fall;
    logic [20:0] cnt;
    logic [20:0] cnt_n;
    logic [22:0] fcnt;
    logic        fterm;
    logic        done;
    logic        stuck_hit;
    logic [2:0]  code;

    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
    assign fterm = !rise && (fcnt == LOST_CNT - 23'd1);

    function automatic logic [21:0] nom(input int c);
        return 22'(NOM_MIN + (5 - c) * NOM_STEP);
    endfunction

    // Lower bound written as cnt + TOL >= nom so it cannot underflow.
    always_comb begin
        code = 3'd0;
        for (int c = 1; c <= 5; c++) begin
            if (({1'b0, cnt} + TOL_W >= nom(c)) &&
                ({1'b0, cnt} <= nom(c) + TOL_W)) begin
                code = 3'(c);
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        done      = 1'b0;
        stuck_hit = 1'b0;
        unique case (state)
            WAIT_LOW: begin
                if (!s2) state_n = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    cnt_n   = 21'd1;
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (fall) begin
                    done    = 1'b1;
                    state_n = WAIT_RISE;
                end else if (s2) begin
                    cnt_n = cnt + 21'd1;
                    if (cnt_n == CNT_MAX) begin
                        stuck_hit = 1'b1;
                        state_n   = STUCK;
                    end
                end
            end
            STUCK: begin
                if (!s2) state_n = WAIT_RISE;
            end
            default: state_n = WAIT_LOW;
        endcase
    end

    // Synchroniser resets high so a pulse in progress at reset never
    // looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            s3    <= 1'b1;
            state <= WAIT_LOW;
            cnt   <= '0;
            fcnt  <= '0;
            value <= '0;
            width <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            lost  <= 1'b0;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            s3    <= s2;
            state <= state_n;
            cnt   <= cnt_n;
            valid <= 1'b0;
            err   <= stuck_hit;
            if (rise) begin
                fcnt <= '0;
            end else if (fcnt != LOST_CNT) begin
                fcnt <= fcnt + 23'd1;
            end
            if (done && code != 3'd0) begin
                value <= code;
                width <= cnt;
                valid <= 1'b1;
                lost  <= 1'b0;
            end else if (done) begin
                err <= 1'b1;
            end else if (fterm) begin
                lost  <= 1'b1;
                value <= 3'd0;
            end
        end
    end

endmodule
